sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 avm_clk  in  1  single clock; all logic on posedge.
REQ-004 avm_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_ld_req / i_ld_addr[ADDR_W] / i_ld_wdata[DATA_W]  in  loader write port; write-only.
REQ-006 o_ld_gnt  out  1  one-cycle pulse when the loader access is accepted.
REQ-007 i_cr_req / i_cr_we / i_cr_addr[ADDR_W] / i_cr_wdata[DATA_W]  in  processing-core port; read (we=0) or write (we=1).
REQ-008 o_cr_gnt  out  1  accept pulse; o_cr_rvalid  out  1  read-data strobe; o_cr_rdata  out  DATA_W  read data.
REQ-009 i_dp_req / i_dp_addr[ADDR_W]  in  display read port; o_dp_gnt, o_dp_rvalid  out  1; o_dp_rdata  out  DATA_W.
REQ-010 o_sram_addr  out  ADDR_W; o_sram_dq / o_sram_dq_oe  out  DATA_W / 1  write data and driver enable; i_sram_dq  in  DATA_W.
REQ-011 o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each, active-low SRAM strobes.

Function
REQ-012 The FSM SHALL have states S_IDLE, S_ACCESS and S_DONE; one SRAM access occupies S_ACCESS then S_DONE (2 cycles).
- S_IDLE/S_DONE with any request -> S_ACCESS; S_DONE with no request -> S_IDLE; S_ACCESS -> S_DONE always.
REQ-013 Arbitration SHALL be evaluated in S_IDLE and S_DONE only: display has absolute priority; loader vs core alternate by a 1-bit round-robin pointer toggled after each loader or core grant.
REQ-014 The winner's o_*_gnt SHALL be high for exactly the first S_ACCESS cycle; its addr/we/wdata SHALL be latched at that same edge, so requesters hold req and payload until gnt and may drop req in the gnt cycle.
REQ-015 In S_ACCESS and S_DONE, ce_n=0, lb_n=ub_n=0, o_sram_addr=latched address.
REQ-016 Write: we_n=0 in S_ACCESS only; o_sram_dq=latched wdata and dq_oe=1 in both S_ACCESS and S_DONE (hold time); oe_n=1.
REQ-017 Read: oe_n=0 in S_ACCESS and S_DONE, we_n=1, dq_oe=0; i_sram_dq SHALL be registered at the S_ACCESS->S_DONE edge into the owner's rdata.
REQ-018 o_*_rvalid SHALL pulse for the single S_DONE cycle of that owner's read; rdata SHALL hold its value until the owner's next read.
REQ-019 Latency: req sampled at edge N in S_IDLE -> gnt in cycle N+1, rvalid in cycle N+2; back-to-back throughput one access per 2 cycles.
REQ-020 Simultaneous loader+core+display requests SHALL be served display first, then loader/core in pointer order; continuous display requests MAY starve the others (accepted by design: display bandwidth is below 50 %).
REQ-021 A request deasserted before its gnt SHALL be ignored without side effect; o_cr_rvalid SHALL never assert for a core write.
REQ-022 Address arithmetic SHALL be pass-through; no wrap or offset applied.
REQ-023 No two gnt outputs and no two rvalid outputs SHALL ever be high in the same cycle.

Reset
REQ-024 On avm_rst_n low, asynchronously: state S_IDLE, all gnt/rvalid 0, all rdata 0, o_sram_addr 0, dq_oe 0, ce_n/oe_n/we_n/lb_n/ub_n 1, round-robin pointer = loader.
REQ-025 Reset asserted mid-access SHALL abort it immediately (we_n returns high in the same cycle), and no gnt or rvalid is issued for the aborted access after release.

Verification
REQ-026 Loader alone, addr 0x00010, wdata 0xA5C3 -> ld_gnt cycle+1, we_n low one cycle, dq_oe high two cycles, dq=0xA5C3, addr=0x00010.
REQ-027 Core read of addr 0xFFFFF, SRAM model returns 0x1234 -> cr_gnt cycle+1, cr_rvalid cycle+2 with cr_rdata=0x1234, we_n stays 1.
REQ-028 Loader, core and display all request at reset release, held -> grant order dp, ld, cr, ld, cr..., gnts spaced 2 cycles apart.
REQ-029 Display held constantly high, loader requesting -> only dp grants issued; drop dp -> ld gnt within 2 cycles.
REQ-030 Reset pulsed low during S_ACCESS of a write -> strobes all 1 in the same cycle, no gnt/rvalid afterward, pointer back to loader.
REQ-031 Core req raised then dropped one cycle before it would win (display busy) -> no cr_gnt, no SRAM access to its address.

Source files
------------

// File: rtl/sram_arbiter.sv
// Three-port SRAM arbiter (display > loader/core round-robin) driving an async SRAM.
// Latency: gnt one cycle after req is sampled, read data one cycle later; 2 cycles per access.
// Backpressure: requesters hold req/payload until gnt; display may starve loader/core while it keeps requesting.
module sram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              avm_clk,
    input  logic              avm_rst_n,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic              o_ld_gnt,
    input  logic              i_cr_req,
    input  logic              i_cr_we,
    input  logic [ADDR_W-1:0] i_cr_addr,
    input  logic [DATA_W-1:0] i_cr_wdata,
    output logic              o_cr_gnt,
    output logic              o_cr_rvalid,
    output logic [DATA_W-1:0] o_cr_rdata,
    input  logic              i_dp_req,
    input  logic [ADDR_W-1:0] i_dp_addr,
    output logic              o_dp_gnt,
    output logic              o_dp_rvalid,
    output logic [DATA_W-1:0] o_dp_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_LD, OWN_CR, OWN_DP} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              ptr_q, ptr_d;      // 0: loader preferred, 1: core preferred
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ld_gnt_q, ld_gnt_d;
    logic              cr_gnt_q, cr_gnt_d;
    logic              dp_gnt_q, dp_gnt_d;
    logic              cr_rvalid_q, cr_rvalid_d;
    logic              dp_rvalid_q, dp_rvalid_d;
    logic [DATA_W-1:0] cr_rdata_q, cr_rdata_d;
    logic [DATA_W-1:0] dp_rdata_q, dp_rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;

    logic pick_ld, pick_cr;

    always_comb begin
        pick_ld = !i_dp_req && i_ld_req && (!i_cr_req || !ptr_q);
        pick_cr = !i_dp_req && i_cr_req && (!i_ld_req || ptr_q);

        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ld_gnt_d    = 1'b0;
        cr_gnt_d    = 1'b0;
        dp_gnt_d    = 1'b0;
        cr_rvalid_d = 1'b0;
        dp_rvalid_d = 1'b0;
        cr_rdata_d  = cr_rdata_q;
        dp_rdata_d  = dp_rdata_q;

        case (state_q)
            S_ACCESS: begin
                state_d = S_DONE;
                // Read data is captured at the end of the first access cycle.
                if (!we_q && owner_q == OWN_CR) begin
                    cr_rdata_d  = i_sram_dq;
                    cr_rvalid_d = 1'b1;
                end
                if (!we_q && owner_q == OWN_DP) begin
                    dp_rdata_d  = i_sram_dq;
                    dp_rvalid_d = 1'b1;
                end
            end
            default: begin
                if (i_dp_req) begin
                    state_d  = S_ACCESS;
                    owner_d  = OWN_DP;
                    we_d     = 1'b0;
                    addr_d   = i_dp_addr;
                    dp_gnt_d = 1'b1;
                end else if (pick_ld) begin
                    state_d  = S_ACCESS;
                    owner_d  = OWN_LD;
                    we_d     = 1'b1;
                    addr_d   = i_ld_addr;
                    wdata_d  = i_ld_wdata;
                    ld_gnt_d = 1'b1;
                    ptr_d    = ~ptr_q;
                end else if (pick_cr) begin
                    state_d  = S_ACCESS;
                    owner_d  = OWN_CR;
                    we_d     = i_cr_we;
                    addr_d   = i_cr_addr;
                    wdata_d  = i_cr_wdata;
                    cr_gnt_d = 1'b1;
                    ptr_d    = ~ptr_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Strobes are registered from the next state so they line up with the access cycles.
        ce_n_d  = (state_d == S_IDLE);
        we_n_d  = !(state_d == S_ACCESS && we_d);
        oe_n_d  = (state_d == S_IDLE) || we_d;
        dq_oe_d = (state_d != S_IDLE) && we_d;
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_LD;
            ptr_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ld_gnt_q    <= 1'b0;
            cr_gnt_q    <= 1'b0;
            dp_gnt_q    <= 1'b0;
            cr_rvalid_q <= 1'b0;
            dp_rvalid_q <= 1'b0;
            cr_rdata_q  <= '0;
            dp_rdata_q  <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ld_gnt_q    <= ld_gnt_d;
            cr_gnt_q    <= cr_gnt_d;
            dp_gnt_q    <= dp_gnt_d;
            cr_rvalid_q <= cr_rvalid_d;
            dp_rvalid_q <= dp_rvalid_d;
            cr_rdata_q  <= cr_rdata_d;
            dp_rdata_q  <= dp_rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign o_ld_gnt     = ld_gnt_q;
    assign o_cr_gnt     = cr_gnt_q;
    assign o_dp_gnt     = dp_gnt_q;
    assign o_cr_rvalid  = cr_rvalid_q;
    assign o_dp_rvalid  = dp_rvalid_q;
    assign o_cr_rdata   = cr_rdata_q;
    assign o_dp_rdata   = dp_rdata_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_dq    = wdata_q;
    assign o_sram_dq_oe = dq_oe_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = oe_n_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_lb_n  = ce_n_q;
    assign o_sram_ub_n  = ce_n_q;

endmodule
